mul_22b_12b_int: RTL and testbench

Sequential shift-add integer multiplier for MPC-II: p = a × b (+ c), with a 22-bit unsigned multiplicand, a 12-bit unsigned multiplier and an optional 12-bit addend. It is the inverse of the 22b/12b divider: a quotient, divisor and remainder go in, and the original dividend comes out. It sits beside the divider in the arithmetic unit and uses the same startp/busy sequencing, one multiplier bit per clock.

---
 rtl/mpc_arith_pkg.sv | 38 +++
 rtl/mul_acc_step.sv | 30 +++
 rtl/mul_22b_12b_int.sv | 127 ++++++++++++
 tb/tb_mul_22b_12b_int.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mpc_arith_pkg.sv
// -----------------------------------------------------------------------------
// mpc_arith_pkg
//   Constants shared by the MPC-II arithmetic unit: the 22b/12b divider and its
//   inverse, the 22b x 12b shift-add multiplier.
//
// Configuration macro: MUL_ADDEND_EN
//   defined   -> multiplier adds a 12-bit addend; one extra cycle (NCYC=13)
//   undefined -> plain multiply (NCYC=12)
// -----------------------------------------------------------------------------
package mpc_arith_pkg;

  localparam int ZW = 22;  // multiplicand / quotient width
  localparam int DW = 12;  // multiplier / divisor / remainder width
  localparam int PW = 34;  // product / dividend width
  localparam int CW = 5;   // cycle counter width

`ifdef MUL_ADDEND_EN
  localparam logic [CW-1:0] MUL_NCYC = 5'd13;
  localparam logic [CW-1:0] MUL_NA   = 5'd1;
`else
  localparam logic [CW-1:0] MUL_NCYC = 5'd12;
  localparam logic [CW-1:0] MUL_NA   = 5'd0;
`endif

  // Multiplier phase, decoded from the cycle counter.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ADD  = 2'd2
  } mul_state_e;

  function automatic mul_state_e mul_decode(input logic [CW-1:0] cnt);
    if (cnt == '0)          return ST_IDLE;
    else if (cnt > MUL_NA)  return ST_MUL;
    else                    return ST_ADD;
  endfunction

endpackage

// File: rtl/mul_acc_step.sv
// -----------------------------------------------------------------------------
// mul_acc_step
//   One shift-add multiplier step. The low 12 bits of the product register
//   hold the not-yet-consumed multiplier bits; bit 0 decides whether the
//   multiplicand is added into the upper 22 bits. The 23-bit sum and the
//   remaining multiplier bits are then shifted right by one.
//
// Ports:
//   i_pr       [33:0] current product register
//   i_ar       [21:0] multiplicand
//   o_pr_next  [33:0] product register after this step
// -----------------------------------------------------------------------------
module mul_acc_step
  import mpc_arith_pkg::*;
(
  input  logic [PW-1:0] i_pr,
  input  logic [ZW-1:0] i_ar,
  output logic [PW-1:0] o_pr_next
);

  logic [ZW:0] w_addend;
  logic [ZW:0] w_sum;

  always_comb begin
    w_addend  = i_pr[0] ? {1'b0, i_ar} : '0;
    w_sum     = {1'b0, i_pr[PW-1:DW]} + w_addend;
    o_pr_next = {w_sum, i_pr[DW-1:1]};
  end

endmodule

// File: rtl/mul_22b_12b_int.sv
// -----------------------------------------------------------------------------
// mul_22b_12b_int
//   Sequential shift-add multiplier, p = a * b (+ c). One multiplier bit per
//   clock, LSB first. Inverse of the 22b/12b divider: quotient, divisor and
//   remainder in, original dividend out.
//
// Configuration macro: MUL_ADDEND_EN (adds port c and a final ADD cycle).
//
// Ports:
//   clk     in       clock, rising edge
//   rst     in       asynchronous reset, active low
//   a       in  22   multiplicand, sampled with startp
//   b       in  12   multiplier, sampled with startp
//   c       in  12   addend, sampled with startp (MUL_ADDEND_EN only)
//   startp  in       start pulse; restarts an operation already in flight
//   p       out 34   product; holds until next startp
//   busy    out      operation in progress
//   done    out      one-cycle pulse when p is valid
//
// State table (decoded from down-counter r_i):
//   ST_IDLE | r_i == 0        : waiting, p holds last result
//   ST_MUL  | r_i >  MUL_NA   : one shift-add step per cycle
//   ST_ADD  | r_i == 1        : add addend (MUL_ADDEND_EN only)
// -----------------------------------------------------------------------------
module mul_22b_12b_int
  import mpc_arith_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [ZW-1:0] a,
  input  logic [DW-1:0] b,
`ifdef MUL_ADDEND_EN
  input  logic [DW-1:0] c,
`endif
  input  logic          startp,
  output logic [PW-1:0] p,
  output logic          busy,
  output logic          done
);

  logic [CW-1:0] r_i;
  logic [ZW-1:0] r_ar;
  logic [PW-1:0] r_pr;
  logic          r_done;

  logic [CW-1:0] w_i_nxt;
  logic [ZW-1:0] w_ar_nxt;
  logic [PW-1:0] w_pr_nxt;
  logic          w_done_nxt;
  logic [PW-1:0] w_pr_step;
  mul_state_e    w_state;

`ifdef MUL_ADDEND_EN
  logic [DW-1:0] r_cr;
  logic [DW-1:0] w_cr_nxt;
`endif

  mul_acc_step u_step (
    .i_pr      (r_pr),
    .i_ar      (r_ar),
    .o_pr_next (w_pr_step)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i    <= '0;
      r_ar   <= '0;
      r_pr   <= '0;
      r_done <= 1'b0;
`ifdef MUL_ADDEND_EN
      r_cr   <= '0;
`endif
    end else begin
      r_i    <= w_i_nxt;
      r_ar   <= w_ar_nxt;
      r_pr   <= w_pr_nxt;
      r_done <= w_done_nxt;
`ifdef MUL_ADDEND_EN
      r_cr   <= w_cr_nxt;
`endif
    end
  end

  // Next-state logic; startp always wins, including over a finishing cycle.
  always_comb begin
    w_state    = mul_decode(r_i);
    w_i_nxt    = r_i;
    w_ar_nxt   = r_ar;
    w_pr_nxt   = r_pr;
`ifdef MUL_ADDEND_EN
    w_cr_nxt   = r_cr;
`endif
    if (startp) begin
      w_i_nxt  = MUL_NCYC;
      w_ar_nxt = a;
      w_pr_nxt = {{ZW{1'b0}}, b};
`ifdef MUL_ADDEND_EN
      w_cr_nxt = c;
`endif
    end else begin
      case (w_state)
        ST_MUL: begin
          w_pr_nxt = w_pr_step;
          w_i_nxt  = r_i - 5'd1;
        end
`ifdef MUL_ADDEND_EN
        ST_ADD: begin
          w_pr_nxt = r_pr + {{ZW{1'b0}}, r_cr};
          w_i_nxt  = r_i - 5'd1;
        end
`endif
        default: ;
      endcase
    end
    // done marks the 1 -> 0 transition of the counter, unless restarted.
    w_done_nxt = !startp && (r_i == 5'd1);
  end

  // Outputs
  always_comb begin
    p    = r_pr;
    busy = (r_i != '0);
    done = r_done;
  end

endmodule

// File: tb/tb_mul_22b_12b_int.sv
module tb_mul_22b_12b_int;

`ifdef MUL_ADDEND_EN
  localparam int NCYC = 13;
`else
  localparam int NCYC = 12;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [21:0] a = '0;
  logic [11:0] b = '0;
  logic [11:0] c = '0;
  logic        startp = 1'b0;
  logic [33:0] p;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  logic [33:0] exp_q[$];
  int          cyc_q[$];

  mul_22b_12b_int dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
`ifdef MUL_ADDEND_EN
    .c      (c),
`endif
    .startp (startp),
    .p      (p),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Monitor: pops an expectation whenever the DUT reports done.
  always @(negedge clk) begin
    logic [33:0] e;
    int          ec;
    cyc++;
    if (rst && done) begin
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done p=%h at cycle %0d", p, cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        if (p !== e) begin
          errors++;
          $display("FAIL product got=%h expected=%h", p, e);
        end
        checks++;
        if (cyc != ec) begin
          errors++;
          $display("FAIL latency got_cycle=%0d expected_cycle=%0d", cyc, ec);
        end
      end
    end
  end

  task automatic check(input string name, input logic [33:0] got, input logic [33:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic start(input logic [21:0] ta, input logic [11:0] tb_, input logic [11:0] tc,
                       input bit push, input logic [33:0] expv);
    @(negedge clk);
    #1;
    a = ta; b = tb_; c = tc; startp = 1'b1;
    if (push) begin
      exp_q.push_back(expv);
      cyc_q.push_back(cyc + NCYC + 1);
    end
    @(posedge clk);
    #1;
    startp = 1'b0;
  endtask

  // Walks the NCYC busy cycles and the done cycle; bounded by construction.
  task automatic wait_done(input string name);
    bit ok = 1'b1;
    for (int k = 1; k <= NCYC + 1; k++) begin
      @(negedge clk);
      #2;
      if (k <= NCYC) ok &= (busy === 1'b1);
      else           ok &= (busy === 1'b0);
    end
    check({name, "_busy_window"}, {33'h0, ok}, 34'h1);
    check({name, "_sb_drained"}, 34'(exp_q.size()), 34'h0);
  endtask

  task automatic run_op(input string name, input logic [21:0] ta, input logic [11:0] tb_,
                        input logic [11:0] tc, input logic [33:0] expv);
    start(ta, tb_, tc, 1'b1, expv);
    wait_done(name);
  endtask

  initial begin
    int d0;
    // Reset behaviour
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #2;
      check("reset_idle", {p, busy, done} , 36'h0);
    end

`ifdef MUL_ADDEND_EN
    run_op("basic",     22'd3,       12'd5,     12'd0,     34'd15);
    run_op("k1000",     22'd1000,    12'd1000,  12'd7,     34'd1000007);
    run_op("a_zero",    22'd0,       12'd123,   12'd45,    34'd45);
    run_op("b_zero",    22'd1234,    12'd0,     12'd9,     34'd9);
    run_op("max",       22'h3FFFFF,  12'hFFF,   12'hFFF,   34'h3_FFC0_0000);
    run_op("roundtrip", 22'd1526,    12'd2748,  12'd855,   34'h0_003F_FFFF);
    run_op("pow2",      22'h200000,  12'h800,   12'd0,     34'h1_0000_0000);
`else
    run_op("basic",     22'd3,       12'd5,     12'd0,     34'd15);
    run_op("k1000",     22'd1000,    12'd1000,  12'd0,     34'd1000000);
    run_op("a_zero",    22'd0,       12'd123,   12'd0,     34'd0);
    run_op("b_zero",    22'd1234,    12'd0,     12'd0,     34'd0);
    run_op("max",       22'h3FFFFF,  12'hFFF,   12'd0,     34'h3_FFBF_F001);
    run_op("roundtrip", 22'd1526,    12'd2748,  12'd0,     34'h0_003F_FCA8);
    run_op("pow2",      22'h200000,  12'h800,   12'd0,     34'h1_0000_0000);
`endif
    run_op("ident",     22'h3FFFFF,  12'd1,     12'd0,     34'h0_003F_FFFF);

    // Restart mid-operation: only the second operation reports done.
    d0 = done_cnt;
    start(22'd100, 12'd7, 12'd0, 1'b0, '0);
    repeat (4) @(negedge clk);
    start(22'd9, 12'd9, 12'd0, 1'b1, 34'd81);
    wait_done("restart");
    repeat (3) @(negedge clk);
    check("restart_one_done", 34'(done_cnt - d0), 34'd1);

    // Reset mid-operation: immediate clear, no done, then a clean operation.
    d0 = done_cnt;
    start(22'd100, 12'd7, 12'd0, 1'b0, '0);
    repeat (5) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_busy", {33'h0, busy}, 34'h0);
    check("rst_mid_p", p, 34'h0);
    check("rst_mid_done", {33'h0, done}, 34'h0);
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (NCYC + 3) @(negedge clk);
    check("rst_mid_no_done", 34'(done_cnt - d0), 34'd0);
    run_op("after_rst", 22'd2, 12'd2, 12'd0, 34'd4);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
